arb_smux: RTL and testbench
===========================

ARB_SMUX -- requirements
Module: arb_smux

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (1..64).
REQ-002 Parameter N, default 4, number of input channels (2..16).
REQ-003 Parameter MODE, default 0, arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low; one clock.
REQ-006 in_data  input  N*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N  per-channel beat valid.
REQ-008 in_last  input  N  per-channel end-of-packet marker, qualified by in_valid.
REQ-009 in_ready  output  N  per-channel accept, combinational.
REQ-010 out_data  output  WIDTH  registered selected beat.
REQ-011 out_last  output  1  registered end-of-packet of out_data.
REQ-012 out_ch  output  max(1,$clog2(N))  registered source channel index of out_data.
REQ-013 out_valid  output  1  registered output valid.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Two states, IDLE (no grant) and BUSY (grant held by channel g).
REQ-016 IDLE: if any in_valid is high at an edge, g SHALL be set to the winner and state SHALL go to BUSY; otherwise stay IDLE.
REQ-017 MODE 0 winner: first valid channel scanning upward from (last_g+1) mod N, wrapping at N-1 -> 0.
REQ-018 MODE 1 winner: lowest-index valid channel; last_g is ignored for selection.
REQ-019 can_acc = !out_valid || out_ready.
REQ-020 in_ready[i] = (state==BUSY) && (i==g) && can_acc; all other bits 0; never more than one bit high.
REQ-021 Transfer when in_valid[g] && in_ready[g]: at the edge, out_data <= channel g data, out_last <= in_last[g], out_ch <= g, out_valid <= 1.
REQ-022 Transfer with in_last[g]=1: state -> IDLE and last_g <= g at the same edge.
REQ-023 Grant is packet-locked: while BUSY, in_valid of other channels is ignored; g dropping in_valid mid-packet holds the grant indefinitely (no timeout).
REQ-024 If out_valid && out_ready and no transfer in that cycle, out_valid <= 0; out_data/out_last/out_ch hold their values.
REQ-025 While out_valid && !out_ready, out_data, out_last, out_ch and out_valid SHALL remain stable.
REQ-026 Latency: in_valid rises in IDLE before edge k -> grant at edge k -> beat accepted at edge k+1 -> out_valid high after edge k+1 (2 cycles).
REQ-027 Throughput: 1 beat/cycle within a packet when out_ready stays high; exactly one IDLE bubble cycle between packets.
REQ-028 Single-beat packet (in_last on first beat) SHALL be legal: grant, transfer, release.
REQ-029 Out-of-range channel indices never occur; for N not a power of two, the scan SHALL wrap at N-1, not at 2^width-1.

Reset
REQ-030 rst_n low at an edge: state <= IDLE, last_g <= N-1 (channel 0 wins first in MODE 0), g <= 0, out_valid <= 0, out_data <= 0, out_last <= 0, out_ch <= 0.
REQ-031 Reset mid-packet SHALL abandon the packet and any held output beat; in_ready SHALL be all-0 during the reset cycle and the cycle after.

Verification
REQ-032 N=4, MODE 0, ch0..3 each a 1-beat packet valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0 with one bubble between beats.
REQ-033 MODE 1, ch1 and ch3 valid -> ch1 granted each time it is valid; ch3 granted only in IDLE cycles where ch1 in_valid is low.
REQ-034 ch2 sends 3-beat packet A,B,C (last on C) while ch0 valid throughout -> out_data A,B,C consecutive on out_ch=2, then ch0 granted.
REQ-035 out_ready held 0 for 5 cycles with beat 0x5A held -> out_data=0x5A, out_valid=1 stable; in_ready[g]=0; on out_ready=1 next beat accepted same cycle.
REQ-036 rst_n low for 1 cycle in the middle of a 4-beat packet on ch1 -> out_valid=0 next cycle, state IDLE, next grant goes to lowest valid channel (MODE 0 from last_g=N-1).
REQ-037 N=3, MODE 0, last grant ch2, all valid -> next grant ch0 (wrap at N-1).

Source files
------------

// File: rtl/arb_smux.sv
// Packet-locked N:1 stream arbiter/mux with a one-deep registered output stage.
// MODE 0 rotates priority after each packet; MODE 1 always favours the lowest index.
module arb_smux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [CW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     g_q;
    logic [CW-1:0]     last_g_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_last_q;
    logic [CW-1:0]     out_ch_q;
    logic              out_valid_q;

    logic [CW-1:0]     winner_d;
    logic              win_found_d;
    logic [CW:0]       base_d;
    logic [CW:0]       pick_d;
    logic [N-1:0]      rot_d;
    logic              can_acc;
    logic              xfer;
    logic [WIDTH-1:0]  ch_data [N];

    assign can_acc = !out_valid_q || out_ready;

    // in_ready is forced low while rst_n is asserted so nothing is consumed by a dying packet.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = rst_n && (state_q == BUSY) && (g_q == CW'(gi)) && can_acc;
        end
    endgenerate

    assign xfer = in_valid[g_q] && in_ready[g_q];

    // Round-robin: rotate the doubled request vector so bit 0 is channel last_g+1.
    always_comb begin
        winner_d    = '0;
        win_found_d = 1'b0;
        pick_d      = '0;
        base_d      = {1'b0, last_g_q} + (CW+1)'(1);
        rot_d       = N'({in_valid, in_valid} >> base_d);
        if (MODE == 1) begin
            for (int j = 0; j < N; j++) begin
                if (!win_found_d && in_valid[j]) begin
                    win_found_d = 1'b1;
                    winner_d    = CW'(j);
                end
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (!win_found_d && rot_d[j]) begin
                    win_found_d = 1'b1;
                    pick_d      = base_d + (CW+1)'(j);
                end
            end
            if (pick_d >= (CW+1)'(N)) begin
                pick_d = pick_d - (CW+1)'(N);
            end
            winner_d = pick_d[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            g_q         <= '0;
            last_g_q    <= CW'(N - 1);
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready && !xfer) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        g_q     <= winner_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        out_data_q  <= ch_data[g_q];
                        out_last_q  <= in_last[g_q];
                        out_ch_q    <= g_q;
                        out_valid_q <= 1'b1;
                        if (in_last[g_q]) begin
                            state_q  <= IDLE;
                            last_g_q <= g_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_smux.sv
// Bench for arb_smux: three instances (N=4 RR, N=4 fixed priority, N=3 RR) checked
// every cycle against a transaction-level model, plus directed arbitration scenarios.
module tb_arb_smux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        out_ready;
    logic [31:0] in_data_a  [3];
    logic [3:0]  in_valid_a [3];
    logic [3:0]  in_last_a  [3];

    logic [3:0] rdy0, rdy1;
    logic [2:0] rdy2;
    logic [7:0] od0, od1, od2;
    logic       ol0, ol1, ol2, ov0, ov1, ov2;
    logic [1:0] oc0, oc1, oc2;

    logic [3:0] rdy_a [3];
    logic [7:0] od_a  [3];
    logic       ol_a  [3];
    logic       ov_a  [3];
    logic [1:0] oc_a  [3];

    always_comb begin
        rdy_a[0] = rdy0; rdy_a[1] = rdy1; rdy_a[2] = {1'b0, rdy2};
        od_a[0]  = od0;  od_a[1]  = od1;  od_a[2]  = od2;
        ol_a[0]  = ol0;  ol_a[1]  = ol1;  ol_a[2]  = ol2;
        ov_a[0]  = ov0;  ov_a[1]  = ov1;  ov_a[2]  = ov2;
        oc_a[0]  = oc0;  oc_a[1]  = oc1;  oc_a[2]  = oc2;
    end

    arb_smux #(.WIDTH(8), .N(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[0]), .in_valid(in_valid_a[0]),
        .in_last(in_last_a[0]), .in_ready(rdy0), .out_data(od0), .out_last(ol0),
        .out_ch(oc0), .out_valid(ov0), .out_ready(out_ready));
    arb_smux #(.WIDTH(8), .N(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[1]), .in_valid(in_valid_a[1]),
        .in_last(in_last_a[1]), .in_ready(rdy1), .out_data(od1), .out_last(ol1),
        .out_ch(oc1), .out_valid(ov1), .out_ready(out_ready));
    arb_smux #(.WIDTH(8), .N(3), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a[2][23:0]), .in_valid(in_valid_a[2][2:0]),
        .in_last(in_last_a[2][2:0]), .in_ready(rdy2), .out_data(od2), .out_last(ol2),
        .out_ch(oc2), .out_valid(ov2), .out_ready(out_ready));

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: one entry per instance.
    int         nn [3] = '{4, 4, 3};
    int         mm [3] = '{0, 1, 0};
    bit         m_busy [3];
    int         m_g    [3];
    int         m_last [3];
    bit         m_ov   [3];
    bit         m_ol   [3];
    logic [7:0] m_od   [3];
    int         m_och  [3];

    int q0[$];
    int q1[$];
    int q2[$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(int d);
        int w = -1;
        for (int k = 0; k < nn[d]; k++) begin
            int c;
            c = (mm[d] == 1) ? k : (m_last[d] + 1 + k) % nn[d];
            if (w < 0 && in_valid_a[d][c]) w = c;
        end
        return w;
    endfunction

    task automatic model_reset(int d);
        m_busy[d] = 1'b0; m_g[d] = 0; m_last[d] = nn[d] - 1;
        m_ov[d] = 1'b0; m_ol[d] = 1'b0; m_od[d] = 8'h00; m_och[d] = 0;
    endtask

    // Called just after an active edge: checks ready before the next edge, then outputs after it.
    task automatic step();
        logic [3:0] er;
        bit xf;
        int w;
        #3;
        for (int d = 0; d < 3; d++) begin
            er = '0;
            if (rst_n && m_busy[d] && (!m_ov[d] || out_ready)) er[m_g[d]] = 1'b1;
            check($sformatf("in_ready[u%0d]", d), rdy_a[d], er);
            if (!rst_n) begin
                model_reset(d);
            end else begin
                xf = er[m_g[d]] && in_valid_a[d][m_g[d]];
                if (m_ov[d] && out_ready && !xf) m_ov[d] = 1'b0;
                if (!m_busy[d]) begin
                    w = winner(d);
                    if (w >= 0) begin
                        m_busy[d] = 1'b1;
                        m_g[d]    = w;
                    end
                end else if (xf) begin
                    m_od[d]  = in_data_a[d][m_g[d]*8 +: 8];
                    m_ol[d]  = in_last_a[d][m_g[d]];
                    m_och[d] = m_g[d];
                    m_ov[d]  = 1'b1;
                    if (in_last_a[d][m_g[d]]) begin
                        m_busy[d] = 1'b0;
                        m_last[d] = m_g[d];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("out_valid[u%0d]", d), ov_a[d], m_ov[d]);
            check($sformatf("out_data[u%0d]", d), od_a[d], m_od[d]);
            check($sformatf("out_last[u%0d]", d), ol_a[d], m_ol[d]);
            check($sformatf("out_ch[u%0d]", d), oc_a[d], m_och[d]);
        end
    endtask

    task automatic drive(logic [3:0] v, logic [3:0] l);
        for (int d = 0; d < 3; d++) begin
            in_valid_a[d] = v;
            in_last_a[d]  = l;
            in_data_a[d]  = $urandom;
        end
    endtask

    task automatic beat(int ch, logic [7:0] val, bit l);
        for (int d = 0; d < 3; d++) begin
            in_data_a[d][ch*8 +: 8] = val;
            in_last_a[d][ch]        = l;
        end
    endtask

    initial begin
        int exp0 [5] = '{0, 1, 2, 3, 0};
        int exp2 [5] = '{0, 1, 2, 0, 1};
        for (int d = 0; d < 3; d++) model_reset(d);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(4'h0, 4'h0);
        step();
        step();
        check("reset out_valid", ov0, 1'b0);
        check("reset out_ch", oc0, 2'd0);
        rst_n = 1'b1;

        // All channels single-beat and continuously valid; u1 sees only ch1 and ch3.
        for (int c = 0; c < 10; c++) begin
            drive(4'hF, 4'hF);
            in_valid_a[1] = 4'b1010;
            step();
            if (ov0) q0.push_back(int'(oc0));
            if (ov1) q1.push_back(int'(oc1));
            if (ov2) q2.push_back(int'(oc2));
        end
        check("rr beat count", q0.size(), 5);
        check("fp beat count", q1.size(), 5);
        check("n3 beat count", q2.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < q0.size()) check($sformatf("rr seq %0d", i), q0[i], exp0[i]);
            if (i < q1.size()) check($sformatf("fp seq %0d", i), q1[i], 1);
            if (i < q2.size()) check($sformatf("n3 wrap seq %0d", i), q2[i], exp2[i]);
        end

        // Fixed priority: ch3 wins only when ch1 is idle.
        drive(4'b1000, 4'hF);
        step();
        step();
        check("fp ch3 alone", oc1, 2'd3);

        // Single-beat packet on ch1 brings u0's last_g to 1.
        drive(4'b0010, 4'b0010);
        beat(1, 8'h11, 1'b1);
        step();
        step();
        check("single beat ch", oc0, 2'd1);
        check("single beat data", od0, 8'h11);

        // Three-beat packet on ch2 while ch0 keeps requesting.
        drive(4'b0101, 4'b0000);
        beat(2, 8'hA1, 1'b0);
        beat(0, 8'hC0, 1'b1);
        step();
        step();
        check("pkt beat A", od0, 8'hA1);
        check("pkt beat A ch", oc0, 2'd2);
        beat(2, 8'hB2, 1'b0);
        step();
        check("pkt beat B", od0, 8'hB2);
        beat(2, 8'hC3, 1'b1);
        step();
        check("pkt beat C", od0, 8'hC3);
        check("pkt beat C last", ol0, 1'b1);
        in_valid_a[0] = 4'b0001;
        step();
        step();
        check("ch0 after pkt", oc0, 2'd0);
        check("ch0 data", od0, 8'hC0);

        // Backpressure holds the 0x5A beat stable.
        drive(4'b0010, 4'b0000);
        beat(1, 8'h5A, 1'b0);
        step();
        step();
        out_ready = 1'b0;
        beat(1, 8'h77, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step();
            check("stall data", od0, 8'h5A);
            check("stall valid", ov0, 1'b1);
            check("stall ready", rdy0, 4'b0000);
        end
        out_ready = 1'b1;
        step();
        check("release data", od0, 8'h77);
        check("release last", ol0, 1'b1);

        // Reset in the middle of a 4-beat packet on ch1.
        drive(4'b0010, 4'b0000);
        step();
        step();
        step();
        rst_n = 1'b0;
        drive(4'b1010, 4'b0000);
        step();
        check("mid-reset out_valid", ov0, 1'b0);
        rst_n = 1'b1;
        step();
        check("post-reset ready", rdy0, 4'b0010);
        step();
        check("post-reset grant", oc0, 2'd1);

        // Random traffic, backpressure and occasional resets.
        for (int c = 0; c < 400; c++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int d = 0; d < 3; d++) begin
                in_valid_a[d] = 4'($urandom);
                in_last_a[d]  = 4'($urandom & $urandom);
                in_data_a[d]  = $urandom;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
